edge_generator: RTL and testbench

Pulse-to-waveform generator: the inverse of the edge detector. It converts single-cycle trigger pulses on `trig_in` into a clean output waveform on `level_out`. Each trigger produces a rising edge, a fixed-width high phase and a guaranteed minimum low gap. Triggers that arrive while a waveform is in progress are either queued and replayed, or dropped and flagged. Intended to drive strobes and enables whose consumers re-detect the edges downstream.

---
 rtl/edge_pkg.sv | 21 ++
 rtl/edge_generator.sv | 120 ++++++++++++
 tb/tb_edge_generator.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
// Shared types and defaults for the edge_generator pulse-to-waveform block.
package edge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } edge_gen_state_t;

  localparam int unsigned DEF_HIGH_CYCLES = 4;
  localparam int unsigned DEF_LOW_CYCLES  = 2;
  localparam int unsigned DEF_QCNT_W      = 3;

  // Phase counter must hold max(HIGH,LOW)-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned h, input int unsigned l);
    int unsigned m;
    m = (h > l) ? h : l;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/edge_generator.sv
// Converts single-cycle triggers into high/low waveforms with a minimum low gap.
// Define EDGE_GEN_QUEUE_EN to queue triggers arriving mid-waveform instead of dropping them.
module edge_generator
  import edge_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int unsigned LOW_CYCLES  = DEF_LOW_CYCLES,
  parameter int unsigned QCNT_W      = DEF_QCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_in,
  output logic              level_out,
  output logic              busy,
  output logic              drop,
  output logic [QCNT_W-1:0] pend_cnt
);

  localparam int unsigned      CNT_W    = cnt_width(HIGH_CYCLES, LOW_CYCLES);
  localparam logic [CNT_W-1:0] HIGH_RLD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_RLD  = CNT_W'(LOW_CYCLES - 1);

  edge_gen_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q;
  logic             drop_q, drop_d;
  logic             busy_w;
  logic             last_low;
  logic             start;

  assign busy_w   = (state_q != IDLE);
  assign last_low = (state_q == LOW) && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= (state_d == HIGH);
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (trig_in) begin
          state_d = HIGH;
          cnt_d   = HIGH_RLD;
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          state_d = LOW;
          cnt_d   = LOW_RLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (start) begin
          state_d = HIGH;
          cnt_d   = HIGH_RLD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy      = busy_w;
    level_out = level_q;
    drop      = drop_q;
  end

`ifdef EDGE_GEN_QUEUE_EN
  logic [QCNT_W-1:0] pend_q, pend_d;
  logic              pend_nz, pend_sat, accept, dequeue;

  assign pend_nz  = (pend_q != '0);
  assign pend_sat = &pend_q;

  // A trigger in the final low cycle with an empty queue launches the next
  // waveform directly and never touches the counter.
  always_comb begin
    dequeue = last_low && pend_nz;
    start   = last_low && (pend_nz || trig_in);
    accept  = trig_in && busy_w && !pend_sat && !(last_low && !pend_nz);
    drop_d  = trig_in && busy_w && pend_sat;
    pend_d  = pend_q;
    if (accept && !dequeue)      pend_d = pend_q + QCNT_W'(1);
    else if (!accept && dequeue) pend_d = pend_q - QCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_q <= '0;
    else      pend_q <= pend_d;
  end

  assign pend_cnt = pend_q;
`else
  assign start    = 1'b0;
  assign drop_d   = trig_in && busy_w;
  assign pend_cnt = '0;
`endif

endmodule

// File: tb/tb_edge_generator.sv
// Randomized bench for edge_generator with a period-position reference model.
module tb_edge_generator;

  localparam int H    = 4;
  localparam int L    = 2;
  localparam int QW   = 3;
  localparam int PMAX = (1 << QW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          trig_in = 1'b0;
  logic          level_out, busy, drop;
  logic [QW-1:0] pend_cnt;

  int total = 0;
  int bad   = 0;

  edge_generator #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .QCNT_W(QW)) dut (
    .clk(clk), .rst(rst), .trig_in(trig_in),
    .level_out(level_out), .busy(busy), .drop(drop), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  // Model: a waveform is "active" and pos counts cycles since its rising edge.
  typedef struct {
    bit active;
    int pos;
    int pend;
    bit drp;
  } m_t;

  m_t m = '{active: 1'b0, pos: 0, pend: 0, drp: 1'b0};

  function automatic m_t step(input m_t c, input bit t);
    m_t n;
    bit last, st, acc;
    n = c;
    n.drp = 1'b0;
    if (!c.active) begin
      if (t) begin
        n.active = 1'b1;
        n.pos    = 0;
      end
    end else begin
      last = (c.pos == H + L - 1);
`ifdef EDGE_GEN_QUEUE_EN
      st     = last && (c.pend > 0 || t);
      acc    = t && !(last && c.pend == 0) && (c.pend < PMAX);
      n.drp  = t && !acc && !(last && c.pend == 0);
      n.pend = c.pend + (acc ? 1 : 0) - ((last && c.pend > 0) ? 1 : 0);
`else
      st    = 1'b0;
      acc   = 1'b0;
      n.drp = t;
`endif
      if (last) begin
        n.active = st;
        n.pos    = 0;
      end else begin
        n.pos = c.pos + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '{active: 1'b0, pos: 0, pend: 0, drp: 1'b0};
    else      m <= step(m, trig_in);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("level_out", int'(level_out), int'(m.active && m.pos < H));
    chk("busy",      int'(busy),      int'(m.active));
    chk("drop",      int'(drop),      int'(m.drp));
    chk("pend_cnt",  int'(pend_cnt),  m.pend);
  end

  // Drive trig for one sampling edge; returns at the following negedge.
  task automatic cyc(input bit t);
    trig_in = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic single_trigger(input string tag);
    int exp_l[6] = '{1, 1, 1, 0, 0, 0};
    int exp_b[6] = '{1, 1, 1, 1, 1, 0};
    cyc(1'b1);
    chk({tag, "_rise_lvl"}, int'(level_out), 1);
    chk({tag, "_rise_busy"}, int'(busy), 1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0);
      chk($sformatf("%s_lvl%0d", tag, i + 1), int'(level_out), exp_l[i]);
      chk($sformatf("%s_busy%0d", tag, i + 1), int'(busy), exp_b[i]);
    end
    chk({tag, "_pend"}, int'(pend_cnt), 0);
  endtask

  initial begin
    int dens;
    #12;
    chk("rst_level", int'(level_out), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_drop",  int'(drop), 0);
    chk("rst_pend",  int'(pend_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cyc(1'b0);

    single_trigger("single");
    cyc(1'b0);

    // Trigger landing exactly in the last low cycle.
    cyc(1'b1);
    repeat (5) cyc(1'b0);
    cyc(1'b1);
`ifdef EDGE_GEN_QUEUE_EN
    chk("lastlow_lvl",  int'(level_out), 1);
    chk("lastlow_busy", int'(busy), 1);
    chk("lastlow_drop", int'(drop), 0);
`else
    chk("lastlow_lvl",  int'(level_out), 0);
    chk("lastlow_busy", int'(busy), 0);
    chk("lastlow_drop", int'(drop), 1);
`endif
    chk("lastlow_pend", int'(pend_cnt), 0);
    repeat (10) cyc(1'b0);

    // Two triggers two cycles apart.
    cyc(1'b1); cyc(1'b0); cyc(1'b1);
`ifdef EDGE_GEN_QUEUE_EN
    chk("pair_pend", int'(pend_cnt), 1);
    chk("pair_drop", int'(drop), 0);
`else
    chk("pair_pend", int'(pend_cnt), 0);
    chk("pair_drop", int'(drop), 1);
`endif
    repeat (16) cyc(1'b0);

    // Trigger held for ten cycles: queue saturates, tenth trigger drops.
    repeat (10) cyc(1'b1);
    chk("hold_drop", int'(drop), 1);
`ifdef EDGE_GEN_QUEUE_EN
    chk("hold_pend", int'(pend_cnt), PMAX);
`else
    chk("hold_pend", int'(pend_cnt), 0);
`endif
    repeat (70) cyc(1'b0);

    // Asynchronous reset in the middle of a high phase.
    repeat (4) cyc(1'b1);
    trig_in = 1'b0;
`ifdef EDGE_GEN_QUEUE_EN
    chk("prerst_pend", int'(pend_cnt), 3);
`endif
    chk("prerst_lvl", int'(level_out), 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_lvl",  int'(level_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pend", int'(pend_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) cyc(1'b0);
    single_trigger("after_rst");

    // Random traffic with varying trigger density and occasional resets.
    dens = 20;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) dens = $urandom_range(0, 100);
      cyc($urandom_range(0, 99) < dens);
      if ($urandom_range(0, 399) == 0) begin
        #1 rst = 1'b0;
        #2 rst = 1'b1;
      end
    end
    trig_in = 1'b0;
    repeat (80) cyc(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
